nes_joypad_port_array: RTL and testbench
========================================

Name: nes_joypad_port_array

Overview:
- Parametrised NES controller-port block. It serves NUM_PADS pads, replacing the fixed two-pad inline joypad shift logic in the NES top level.
- Per pad, it merges three active-high sources: controller buttons, UART-loader buttons and per-button autofire for B/A.
- Per pad, it latches the merged value on the CPU strobe and shifts it out LSB-first on the falling edge of that pad's joypad clock.
- It sits between the controller/loader logic and the NES core's $4016/$4017 read path.

Parameters:
- NUM_PADS, 2, number of controller ports (1..4).
- AF_HALF_PERIOD, 1_000_000, clk cycles per autofire on/off half-period (>=2).
- SHIFT_FILL, 1'b0, bit shifted into the MSB on each shift.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pad_btn  in  NUM_PADS*8  controller buttons, active-high, per pad {R L D U START SELECT B A}; pad i at [8i+7:8i].
- loader_btn  in  NUM_PADS*8  UART-loader buttons, same layout, ORed in.
- af_req  in  NUM_PADS*2  autofire requests; bit 2i = B of pad i, bit 2i+1 = A of pad i.
- joypad_strobe  in  1  NES strobe (level).
- joypad_clock  in  NUM_PADS  per-pad NES read clock.
- joypad_data  out  NUM_PADS  serial data; bit i = shift_reg[i][0].
- snapshot  out  NUM_PADS*8  last value loaded by strobe, for debug.

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - all shift registers = 0, so joypad_data = 0 and snapshot = 0;
  - last_clock register = 0;
  - all autofire channels IDLE with output 0.
- merged[i] = pad_btn[i] | loader_btn[i] | {6'b0, af_out_B[i], af_out_A[i]}. It is combinational from the inputs and the registered af outputs.
- Strobe: on every clk edge where joypad_strobe=1, shift_reg[i] <= merged[i] and snapshot[i] <= merged[i] for all pads. joypad_data reflects the new bit 0 one cycle after strobe is sampled.
- Shift: a falling edge of pad i's clock is detected as last_clock[i]=1 && joypad_clock[i]=0. On it, shift_reg[i] <= {SHIFT_FILL, shift_reg[i][7:1]}. last_clock <= joypad_clock every cycle.
- Simultaneous strobe and falling edge on the same pad: the strobe load wins and the shift is discarded.
- Reading past 8 shifts: after 8 shifts joypad_data[i] = SHIFT_FILL, and it stays there until the next strobe.
- Pads are fully independent. A shift on pad 0 does not affect pad 1.
- Autofire channel FSM (one per B/A per pad), states IDLE, ON, OFF, with a counter cnt of width $clog2(AF_HALF_PERIOD):
  - IDLE: out=0. If req=1, go to ON with cnt=0.
  - ON: out=1. cnt++; at cnt==AF_HALF_PERIOD-1, go to OFF with cnt=0.
  - OFF: out=0. cnt++; at cnt==AF_HALF_PERIOD-1, go to ON with cnt=0.
  - req=0 in any state: IDLE next cycle, out=0 next cycle.
  - out is registered: it is 1 on the cycle after req first samples high.
- Reset asserted mid-shift or mid-autofire: everything returns to the reset values on the next edge. A strobe held during reset is ignored.

Optional Feature:
- Macro JOYPAD_SOCD_EN, applied to merged[i] before load.
- Defined:
  - if merged L and R are both 1, both are forced to 0;
  - if merged U and D are both 1, both are forced to 0;
  - other bits are untouched.
- Undefined: merged is passed through unmodified.

Decomposition:
- Package nes_joypad_pkg holds:
  - button index localparams: BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7;
  - autofire state enum af_state_t {AF_IDLE, AF_ON, AF_OFF}.
- Sub-module nes_autofire_ch (clk, reset, req, out; param HALF_PERIOD), instantiated NUM_PADS*2 times in a generate loop.

Test Plan (all scenarios use AF_HALF_PERIOD=4):
- Load and shift: NUM_PADS=2, pad_btn pad0=8'hA5, strobe 1 cycle high, then 8 falling edges of joypad_clock[0] -> joypad_data[0] reads 1,0,1,0,0,1,0,1, then SHIFT_FILL (0). joypad_data[1] is unchanged throughout.
- Source merge: pad_btn pad1=8'h01, loader_btn pad1=8'h80, strobe -> snapshot[15:8]=8'h81.
- Autofire: af_req bit0 held high for 20 cycles -> out_B = 0 on the first cycle, then repeating 4 cycles 1 / 4 cycles 0. Dropping req -> out_B=0 on the next cycle. A strobe during an ON phase loads bit1=1; during an OFF phase it loads bit1=0.
- Strobe priority: strobe and a joypad_clock[0] falling edge in the same cycle -> register equals merged, no shift applied.
- Reset mid-read: after 3 shifts, assert reset for 1 cycle -> joypad_data=0, snapshot=0, all autofire channels IDLE.
- SOCD (JOYPAD_SOCD_EN defined): pad_btn=8'hF0, strobe -> snapshot=8'h00. Without the macro -> snapshot=8'hF0.

Source files
------------

// File: rtl/nes_joypad_pkg.sv
// nes_joypad_pkg
// Shared definitions for the NES controller-port block: button bit positions
// within a pad byte, the autofire channel state type, and the SOCD cleaner
// used when JOYPAD_SOCD_EN is defined.
package nes_joypad_pkg;

  // Bit positions inside one pad byte {R L D U START SELECT B A}.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Autofire channel states.
  typedef enum logic [1:0] {
    AF_IDLE = 2'd0,
    AF_ON   = 2'd1,
    AF_OFF  = 2'd2
  } af_state_t;

  // Opposing directions pressed together cancel each other out, so the game
  // never sees an impossible L+R or U+D combination. All other bits pass.
  function automatic logic [7:0] socdFilter(input logic [7:0] btn);
    logic [7:0] res;
    res = btn;
    if (btn[BTN_LEFT] && btn[BTN_RIGHT]) begin
      res[BTN_LEFT]  = 1'b0;
      res[BTN_RIGHT] = 1'b0;
    end
    if (btn[BTN_UP] && btn[BTN_DOWN]) begin
      res[BTN_UP]   = 1'b0;
      res[BTN_DOWN] = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/nes_joypad_port_array_autofire.sv
// nes_autofire_ch
// One autofire channel: while req is held, out toggles with HALF_PERIOD clk
// cycles high followed by HALF_PERIOD cycles low, starting high on the cycle
// after req is first sampled. Dropping req returns the channel to idle.
module nes_autofire_ch
  import nes_joypad_pkg::*;
#(
  parameter int HALF_PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic out
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

  af_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          out_q;

  // Channel FSM with a registered output; a low req always wins and parks
  // the channel in idle so re-pressing restarts with a full ON phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= AF_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else if (!req) begin
      state_q <= AF_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      case (state_q)
        AF_IDLE: begin
          state_q <= AF_ON;
          cnt_q   <= '0;
          out_q   <= 1'b1;
        end
        AF_ON: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= AF_OFF;
            cnt_q   <= '0;
            out_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            out_q <= 1'b1;
          end
        end
        AF_OFF: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= AF_ON;
            cnt_q   <= '0;
            out_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            out_q <= 1'b0;
          end
        end
        default: begin
          state_q <= AF_IDLE;
          cnt_q   <= '0;
          out_q   <= 1'b0;
        end
      endcase
    end
  end

  assign out = out_q;

endmodule

// File: rtl/nes_joypad_port_array.sv
// nes_joypad_port_array
// NUM_PADS independent NES controller ports. Each pad merges controller,
// UART-loader and B/A autofire sources, latches the result while the CPU
// strobe is high and shifts it out LSB-first on falling edges of that pad's
// joypad clock. Optional build macro: JOYPAD_SOCD_EN (cancel L+R / U+D).
module nes_joypad_port_array
  import nes_joypad_pkg::*;
#(
  parameter int   NUM_PADS       = 2,
  parameter int   AF_HALF_PERIOD = 1_000_000,
  parameter logic SHIFT_FILL     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PADS*8-1:0] pad_btn,
  input  logic [NUM_PADS*8-1:0] loader_btn,
  input  logic [NUM_PADS*2-1:0] af_req,
  input  logic                  joypad_strobe,
  input  logic [NUM_PADS-1:0]   joypad_clock,
  output logic [NUM_PADS-1:0]   joypad_data,
  output logic [NUM_PADS*8-1:0] snapshot
);

  logic [NUM_PADS*2-1:0] afOut;
  logic [7:0]            merged     [NUM_PADS];
  logic [7:0]            shift_q    [NUM_PADS];
  logic [7:0]            shift_d    [NUM_PADS];
  logic [7:0]            snapshot_q [NUM_PADS];
  logic [7:0]            snapshot_d [NUM_PADS];
  logic [NUM_PADS-1:0]   last_clock_q;
  logic [NUM_PADS-1:0]   fallEdge;

  // Two autofire channels per pad: even index drives B, odd index drives A.
  for (genvar g = 0; g < NUM_PADS * 2; g++) begin : gAutofire
    nes_autofire_ch #(
      .HALF_PERIOD(AF_HALF_PERIOD)
    ) uChannel (
      .clk  (clk),
      .reset(reset),
      .req  (af_req[g]),
      .out  (afOut[g])
    );
  end

  // Merge the three active-high sources per pad, optionally cleaning
  // opposing directions before the value can be latched.
  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      logic [7:0] afBits;
      logic [7:0] raw;
      afBits         = '0;
      afBits[BTN_B]  = afOut[2*i];
      afBits[BTN_A]  = afOut[2*i+1];
      raw            = pad_btn[8*i +: 8] | loader_btn[8*i +: 8] | afBits;
`ifdef JOYPAD_SOCD_EN
      merged[i]      = socdFilter(raw);
`else
      merged[i]      = raw;
`endif
    end
  end

  // Falling edge of a pad clock relative to the value seen last cycle.
  assign fallEdge = last_clock_q & ~joypad_clock;

  // Next-state for each pad: strobe load takes priority over a shift that
  // lands in the same cycle, so the freshly latched bit 0 is never lost.
  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      shift_d[i]    = shift_q[i];
      snapshot_d[i] = snapshot_q[i];
      if (joypad_strobe) begin
        shift_d[i]    = merged[i];
        snapshot_d[i] = merged[i];
      end else if (fallEdge[i]) begin
        shift_d[i] = {SHIFT_FILL, shift_q[i][7:1]};
      end
    end
  end

  // Port state registers; reset also masks any strobe held during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_clock_q <= '0;
      for (int i = 0; i < NUM_PADS; i++) begin
        shift_q[i]    <= '0;
        snapshot_q[i] <= '0;
      end
    end else begin
      last_clock_q <= joypad_clock;
      for (int i = 0; i < NUM_PADS; i++) begin
        shift_q[i]    <= shift_d[i];
        snapshot_q[i] <= snapshot_d[i];
      end
    end
  end

  // Flatten per-pad state onto the output buses.
  for (genvar p = 0; p < NUM_PADS; p++) begin : gOutputs
    assign joypad_data[p]      = shift_q[p][0];
    assign snapshot[8*p +: 8]  = snapshot_q[p];
  end

endmodule

// File: tb/tb_nes_joypad_port_array.sv
// tb_nes_joypad_port_array
// Scoreboard bench for nes_joypad_port_array (NUM_PADS=2, AF_HALF_PERIOD=4).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and
// compares them. Honours JOYPAD_SOCD_EN for the direction-cancel vectors.
module tb_nes_joypad_port_array;

  localparam int NP = 2;
  localparam int HP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   pad_btn;
  logic [15:0]   loader_btn;
  logic [3:0]    af_req;
  logic          joypad_strobe;
  logic [1:0]    joypad_clock;
  wire  [1:0]    joypad_data;
  wire  [15:0]   snapshot;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] mask;
    logic [15:0] exp;
  } exp_t;

  exp_t sbq[$];
  exp_t monItem;
  int   checks = 0;
  int   errors = 0;

  nes_joypad_port_array #(
    .NUM_PADS      (NP),
    .AF_HALF_PERIOD(HP),
    .SHIFT_FILL    (1'b0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pad_btn      (pad_btn),
    .loader_btn   (loader_btn),
    .af_req       (af_req),
    .joypad_strobe(joypad_strobe),
    .joypad_clock (joypad_clock),
    .joypad_data  (joypad_data),
    .snapshot     (snapshot)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Queue an expectation: sel 0 = joypad_data, sel 1 = snapshot.
  task automatic expectOut(input string name, input int sel,
                           input logic [15:0] mask, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.mask = mask;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  // Compare one expectation against the DUT outputs.
  task automatic checkOutput(input exp_t e);
    logic [15:0] act;
    act = (e.sel == 0) ? {14'b0, joypad_data} : snapshot;
    checks++;
    if ((act & e.mask) !== (e.exp & e.mask)) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (mask %h)",
               e.name, act & e.mask, e.exp & e.mask, e.mask);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so drain the scoreboard there.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      monItem = sbq.pop_front();
      checkOutput(monItem);
    end
  end

  // Let one clk edge sample the currently driven inputs.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // One falling edge on pad 0's joypad clock (high for a cycle, then low).
  task automatic fallEdge0();
    joypad_clock[0] = 1'b1;
    applyStimulus();
    joypad_clock[0] = 1'b0;
    applyStimulus();
  endtask

  task automatic strobePulse();
    joypad_strobe = 1'b1;
    applyStimulus();
    joypad_strobe = 1'b0;
  endtask

  logic [7:0] padVal;
  logic       expBit;

  initial begin
    reset         = 1'b1;
    pad_btn       = '0;
    loader_btn    = '0;
    af_req        = '0;
    joypad_strobe = 1'b0;
    joypad_clock  = '0;
    applyStimulus();
    applyStimulus();
    expectOut("resetData", 0, 16'h0003, 16'h0000);
    expectOut("resetSnap", 1, 16'hFFFF, 16'h0000);
    reset = 1'b0;
    applyStimulus();

    // Load and shift: pad0=A5 shifts out, pad1=55 must keep bit0=1.
    padVal  = 8'hA5;
    pad_btn = 16'h55A5;
    strobePulse();
    pad_btn = '0;
    expectOut("loadData", 0, 16'h0003, 16'h0003);
    expectOut("loadSnap", 1, 16'hFFFF, 16'h55A5);
    for (int s = 1; s <= 9; s++) begin
      fallEdge0();
      expBit = (s < 8) ? padVal[s] : 1'b0;
      expectOut($sformatf("shift%0d", s), 0, 16'h0003, {14'b0, 1'b1, expBit});
    end

    // Source merge on both pads.
    pad_btn    = 16'h0102;
    loader_btn = 16'h8010;
    strobePulse();
    pad_btn    = '0;
    loader_btn = '0;
    expectOut("mergeSnap", 1, 16'hFFFF, 16'h8112);

    // Autofire B of pad 0 with strobe held so snapshot tracks merged.
    af_req        = 4'b0001;
    joypad_strobe = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus();
      expBit = (k == 1) ? 1'b0 : ((((k - 2) / 4) % 2) == 0);
      expectOut($sformatf("afB_k%0d", k), 1, 16'hFFFF, {14'b0, expBit, 1'b0});
    end
    af_req = 4'b0000;
    applyStimulus();
    expectOut("afDrop1", 1, 16'hFFFF, 16'h0002);
    applyStimulus();
    expectOut("afDrop2", 1, 16'hFFFF, 16'h0000);
    joypad_strobe = 1'b0;

    // Autofire A of pad 1 lands on snapshot bit 8.
    af_req        = 4'b1000;
    joypad_strobe = 1'b1;
    applyStimulus();
    expectOut("afA1first", 1, 16'hFFFF, 16'h0000);
    applyStimulus();
    expectOut("afA1on", 1, 16'hFFFF, 16'h0100);
    af_req        = 4'b0000;
    joypad_strobe = 1'b0;
    applyStimulus();
    applyStimulus();

    // Strobe and falling edge together: load wins, no shift.
    pad_btn = 16'h00A5;
    strobePulse();
    joypad_clock[0] = 1'b1;
    applyStimulus();
    joypad_clock[0] = 1'b0;
    pad_btn         = 16'h0002;
    joypad_strobe   = 1'b1;
    applyStimulus();
    joypad_strobe   = 1'b0;
    pad_btn         = '0;
    expectOut("prioData", 0, 16'h0003, 16'h0000);
    expectOut("prioSnap", 1, 16'hFFFF, 16'h0002);
    fallEdge0();
    expectOut("prioShift", 0, 16'h0003, 16'h0001);

    // Reset in the middle of a read with autofire running.
    pad_btn = 16'hFFFF;
    strobePulse();
    pad_btn = '0;
    fallEdge0();
    fallEdge0();
    fallEdge0();
    af_req = 4'b1111;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    expectOut("preResetData", 0, 16'h0003, 16'h0003);
    reset         = 1'b1;
    joypad_strobe = 1'b1;
    pad_btn       = 16'hFFFF;
    applyStimulus();
    expectOut("midResetData", 0, 16'h0003, 16'h0000);
    expectOut("midResetSnap", 1, 16'hFFFF, 16'h0000);
    reset   = 1'b0;
    af_req  = 4'b0000;
    pad_btn = '0;
    applyStimulus();
    expectOut("afIdleAfterReset", 1, 16'hFFFF, 16'h0000);
    joypad_strobe = 1'b0;

    // Opposing directions.
    pad_btn = 16'hC3F0;
    strobePulse();
`ifdef JOYPAD_SOCD_EN
    expectOut("socdCancel", 1, 16'hFFFF, 16'h0300);
`else
    expectOut("socdPass", 1, 16'hFFFF, 16'hC3F0);
`endif
    pad_btn = 16'h0050;
    strobePulse();
    pad_btn = '0;
    expectOut("socdNoConflict", 1, 16'hFFFF, 16'h0050);

    applyStimulus();
    applyStimulus();
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
